// File: rtl/bitcell_array_ctrl_if.sv
// ---------------------------------------------------------------------------
// bitcell_array_ctrl_if
//
// Bundles the two requester ports and the shared response port of
// bitcell_array_ctrl.
//
// Signal summary:
//   req0_valid/req1_valid  requester -> ctrl   request pending
//   req0_ready/req1_ready  ctrl -> requester   request accepted this cycle
//   req0_we/req1_we        requester -> ctrl   1=write, 0=read
//   req0_addr/req1_addr    requester -> ctrl   row address
//   req0_wdata/req1_wdata  requester -> ctrl   write data
//   rsp0_valid/rsp1_valid  ctrl -> requester   one-cycle completion pulse
//   rsp_rdata              ctrl -> requester   read data (with rspN_valid)
//   rsp_err                ctrl -> requester   address out of range
//
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface bitcell_array_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [WIDTH-1:0]  req0_wdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [WIDTH-1:0]  req1_wdata;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bitcell_array_ctrl.sv
// ---------------------------------------------------------------------------
// bitcell_array_ctrl
//
// Sequences a ROWS x WIDTH bitcell array for two round-robin arbitrated
// requesters. A cell writes whenever its select is high and the global read
// line is low, so every write parks data and read=0 before raising select,
// and drops select before read returns high.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   bus       if   slave side of bitcell_array_ctrl_if (requests/responses)
//   busy      out  high in every state except IDLE
//   arr_sel   out  one-hot row select (or all zero)
//   arr_read  out  global read line
//   arr_in    out  column write data
//   arr_out   in   wired-OR of all cell outputs
// ---------------------------------------------------------------------------
module bitcell_array_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 16,
    parameter int ADDR_W    = $clog2(ROWS),
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitcell_array_ctrl_if.slave  bus,
    output logic                 busy,
    output logic [ROWS-1:0]      arr_sel,
    output logic                 arr_read,
    output logic [WIDTH-1:0]     arr_in,
    input  logic [WIDTH-1:0]     arr_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WSETUP = 3'd1;
    localparam logic [2:0] S_WSEL   = 3'd2;
    localparam logic [2:0] S_WHOLD  = 3'd3;
    localparam logic [2:0] S_RSEL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // The dwell counter counts down from N-1 to 0, so it only needs to hold
    // the larger of the two dwell lengths minus one.
    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    // One extra bit so the range check also works when ROWS is a power of two.
    localparam logic [ADDR_W:0]  ROWS_LIM = (ADDR_W + 1)'(ROWS);
    localparam logic [ROWS-1:0]  SEL_ONE  = ROWS'(1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic              id_q;
    logic [ADDR_W-1:0] addr_q;

    logic              idle;
    logic              grant0;
    logic              grant1;
    logic              acc_id;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic              acc_err;

    // Round-robin grant: ptr holds the last served requester, so on a tie the
    // other one wins. Gating with rst_n keeps ready low while reset is held.
    always_comb begin
        idle      = rst_n && (state == S_IDLE);
        grant0    = idle && bus.req0_valid && (!bus.req1_valid || ptr);
        grant1    = idle && bus.req1_valid && (!bus.req0_valid || !ptr);
        acc_id    = grant1;
        acc_we    = grant1 ? bus.req1_we    : bus.req0_we;
        acc_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
        acc_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
        acc_err   = ({1'b0, acc_addr} >= ROWS_LIM);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Main sequencer. arr_in holds the latched write data for the whole
    // write, so no separate wdata register is kept; the state itself records
    // whether the operation is a write or a read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            ptr            <= 1'b1;
            id_q           <= 1'b0;
            addr_q         <= '0;
            busy           <= 1'b0;
            arr_sel        <= '0;
            arr_read       <= 1'b1;
            arr_in         <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        ptr    <= acc_id;
                        id_q   <= acc_id;
                        addr_q <= acc_addr;
                        busy   <= 1'b1;
                        if (acc_err) begin
                            state          <= S_DONE;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_rdata  <= '0;
                            bus.rsp0_valid <= !acc_id;
                            bus.rsp1_valid <= acc_id;
                        end else if (acc_we) begin
                            state    <= S_WSETUP;
                            arr_in   <= acc_wdata;
                            arr_read <= 1'b0;
                        end else begin
                            state   <= S_RSEL;
                            arr_sel <= SEL_ONE << acc_addr;
                            cnt     <= RD_LOAD;
                        end
                    end
                end

                S_WSETUP: begin
                    state   <= S_WSEL;
                    arr_sel <= SEL_ONE << addr_q;
                    cnt     <= WR_LOAD;
                end

                S_WSEL: begin
                    if (cnt == '0) begin
                        state   <= S_WHOLD;
                        arr_sel <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Select is already low here, so read may return high safely.
                S_WHOLD: begin
                    state          <= S_DONE;
                    arr_read       <= 1'b1;
                    bus.rsp0_valid <= !id_q;
                    bus.rsp1_valid <= id_q;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_rdata  <= '0;
                end

                S_RSEL: begin
                    if (cnt == '0) begin
                        state          <= S_DONE;
                        arr_sel        <= '0;
                        bus.rsp_rdata  <= arr_out;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp0_valid <= !id_q;
                        bus.rsp1_valid <= id_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    state          <= S_IDLE;
                    busy           <= 1'b0;
                    bus.rsp0_valid <= 1'b0;
                    bus.rsp1_valid <= 1'b0;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_rdata  <= '0;
                end

                default: begin
                    state          <= S_IDLE;
                    busy           <= 1'b0;
                    arr_sel        <= '0;
                    arr_read       <= 1'b1;
                    bus.rsp0_valid <= 1'b0;
                    bus.rsp1_valid <= 1'b0;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_rdata  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitcell_array_ctrl
//
// Drives bitcell_array_ctrl against a behavioural bitcell array. Expected
// responses are queued at accept time and compared when a response pulse
// appears; directed steps additionally check array timing and arbitration.
// ---------------------------------------------------------------------------
module tb_bitcell_array_ctrl;

    localparam int WIDTH     = 8;
    localparam int ROWS      = 12;
    localparam int ADDR_W    = $clog2(ROWS);
    localparam int WR_CYCLES = 2;
    localparam int RD_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             busy;
    logic [ROWS-1:0]  arr_sel;
    logic             arr_read;
    logic [WIDTH-1:0] arr_in;
    logic [WIDTH-1:0] arr_out;

    bitcell_array_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    bitcell_array_ctrl #(
        .WIDTH(WIDTH), .ROWS(ROWS), .ADDR_W(ADDR_W),
        .WR_CYCLES(WR_CYCLES), .RD_CYCLES(RD_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
        .arr_sel(arr_sel), .arr_read(arr_read), .arr_in(arr_in), .arr_out(arr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bitcell array: write while sel=1 and read=0, drive out
    // while sel=1 and read=1.
    logic [WIDTH-1:0] cells [ROWS] = '{default: '0};

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            if (arr_sel[r] && !arr_read) cells[r] <= arr_in;
    end

    always_comb begin
        arr_out = '0;
        for (int r = 0; r < ROWS; r++)
            if (arr_sel[r] && arr_read) arr_out = arr_out | cells[r];
    end

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard of expected responses.
    typedef struct {
        int               id;
        logic             err;
        logic [WIDTH-1:0] rdata;
        int               due;
    } exp_t;

    exp_t             sbq [$];
    exp_t             mon_e;
    logic [WIDTH-1:0] ref_mem [16] = '{default: '0};
    logic             prev_read = 1'b1;
    logic [ROWS-1:0]  prev_sel  = '0;
    logic             prev_rst  = 1'b0;

    task automatic pushExpected(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [WIDTH-1:0] wdata);
        exp_t e;
        e.id    = id;
        e.err   = (int'(addr) >= ROWS);
        e.rdata = (we || e.err) ? '0 : ref_mem[addr];
        e.due   = cyc + (e.err ? 1 : (we ? 3 + WR_CYCLES : 1 + RD_CYCLES));
        if (we && !e.err) ref_mem[addr] = wdata;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("rsp_unexpected", {bus.rsp1_valid, bus.rsp0_valid}, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("rsp_id", {bus.rsp1_valid, bus.rsp0_valid},
                                (mon_e.id == 0) ? 2'b01 : 2'b10);
                    checkOutput("rsp_err", bus.rsp_err, mon_e.err);
                    checkOutput("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    checkOutput("rsp_latency", cyc, mon_e.due);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
                checkOutput("rsp_timeout", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end

            if (bus.req0_ready || bus.req1_ready)
                checkOutput("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready && bus.req0_valid)
                pushExpected(0, bus.req0_we, bus.req0_addr, bus.req0_wdata);
            if (bus.req1_ready && bus.req1_valid)
                pushExpected(1, bus.req1_we, bus.req1_addr, bus.req1_wdata);

            if (arr_sel != '0)
                checkOutput("sel_onehot", $countones(arr_sel), 1);
            if (prev_rst && (arr_sel != '0 || prev_sel != '0))
                checkOutput("read_stable", arr_read, prev_read);
        end
        prev_read = arr_read;
        prev_sel  = arr_sel;
        prev_rst  = rst_n;
    end

    task automatic setReq(input int id, input logic v, input logic we,
                          input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wdata;
        end
    endtask

    // Presents one request, waits (bounded) for its ready, then drops valid
    // just after the accepting edge. Returns in the first cycle after accept.
    task automatic applyStimulus(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [WIDTH-1:0] wdata);
        int   n   = 0;
        logic got = 1'b0;
        setReq(id, 1'b1, we, addr, wdata);
        while (!got && n < 50) begin
            @(negedge clk);
            if ((id == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
            n++;
        end
        checkOutput("accept_seen", got, 1);
        @(posedge clk); #1;
        setReq(id, 1'b0, we, addr, wdata);
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sbq.size() != 0 || busy) && n < 100);
        checkOutput("idle_reached", (n < 100), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   arb_exp [5] = '{0, 1, 0, 1, 1};
        int   gid;
        int   n;
        logic got;

        // Reset with both requesters asserting.
        rst_n = 1'b0;
        setReq(0, 1'b1, 1'b0, '0, '0);
        setReq(1, 1'b1, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_arr_sel", arr_sel, 0);
        checkOutput("rst_arr_read", arr_read, 1);
        checkOutput("rst_ready0", bus.req0_ready, 0);
        checkOutput("rst_ready1", bus.req1_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp", {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err}, 0);
        checkOutput("rst_rdata", bus.rsp_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_ready0", bus.req0_ready, 1);
        checkOutput("first_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        setReq(0, 1'b0, 1'b0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0);
        waitIdle();

        // Write 0xA5 to row 3 with cycle-by-cycle array checks.
        applyStimulus(0, 1'b1, 4'd3, 8'hA5);
        @(negedge clk);
        checkOutput("wsetup_arr_in", arr_in, 8'hA5);
        checkOutput("wsetup_arr_read", arr_read, 0);
        checkOutput("wsetup_arr_sel", arr_sel, 0);
        @(negedge clk);
        checkOutput("wsel1_arr_sel", arr_sel, 12'h008);
        @(negedge clk);
        checkOutput("wsel2_arr_sel", arr_sel, 12'h008);
        checkOutput("wsel2_arr_in", arr_in, 8'hA5);
        @(negedge clk);
        checkOutput("whold_arr_sel", arr_sel, 0);
        checkOutput("whold_arr_read", arr_read, 0);
        @(negedge clk);
        checkOutput("wdone_rsp0", bus.rsp0_valid, 1);
        checkOutput("wdone_arr_read", arr_read, 1);
        @(posedge clk); #1;
        waitIdle();
        applyStimulus(0, 1'b0, 4'd3, 8'h00);
        waitIdle();

        // Row isolation.
        applyStimulus(0, 1'b1, 4'd4, 8'h3C); waitIdle();
        applyStimulus(0, 1'b1, 4'd3, 8'hFF); waitIdle();
        applyStimulus(0, 1'b0, 4'd4, 8'h00); waitIdle();
        applyStimulus(0, 1'b0, 4'd3, 8'h00); waitIdle();

        // Serve req1 once so req0 is next in line on a tie.
        applyStimulus(1, 1'b1, 4'd5, 8'h5A); waitIdle();

        // Arbitration with both valid continuously, then req1 alone.
        setReq(0, 1'b1, 1'b0, 4'd3, '0);
        setReq(1, 1'b1, 1'b0, 4'd4, '0);
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            gid = -1;
            n   = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    got = 1'b1;
                    gid = bus.req1_ready ? 1 : 0;
                end
                n++;
            end
            checkOutput("arb_seen", got, 1);
            checkOutput($sformatf("arb_grant%0d", g), gid, arb_exp[g]);
            @(posedge clk); #1;
            if (g == 3) bus.req0_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        waitIdle();

        // Out-of-range read from req1.
        applyStimulus(1, 1'b0, 4'd13, 8'h00);
        @(negedge clk);
        checkOutput("oor_rsp1", bus.rsp1_valid, 1);
        checkOutput("oor_err", bus.rsp_err, 1);
        checkOutput("oor_rdata", bus.rsp_rdata, 0);
        checkOutput("oor_arr_sel", arr_sel, 0);
        @(negedge clk);
        checkOutput("oor_arr_sel_after", arr_sel, 0);
        checkOutput("oor_busy_after", busy, 0);
        @(posedge clk); #1;
        waitIdle();

        // Reset during WSEL.
        applyStimulus(0, 1'b1, 4'd3, 8'h11);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_wsel_arr_sel", arr_sel, 12'h008);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mid_rst_arr_sel", arr_sel, 0);
        checkOutput("mid_rst_arr_read", arr_read, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 4'd4, 8'h00); waitIdle();
        applyStimulus(1, 1'b0, 4'd5, 8'h00); waitIdle();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bitcell_array_ctrl.md
Name: bitcell_array_ctrl

Overview:
- Sequences a ROWS x WIDTH array of bitcells: one select line per row, a shared column data-in bus, a global read line, and a wired-OR column data-out bus.
- Arbitrates between two requesters with round-robin, and turns each accepted request into a glitch-safe write or read sequence.
- Bitcell rule the sequencing must honour: a cell writes whenever sel=1 and read=0; a cell drives out only when sel=1 and read=1.

Parameters:
- WIDTH, 8, data bits per row (array columns).
- ROWS, 16, number of rows. Need not be a power of two.
- ADDR_W, $clog2(ROWS), address width (derived).
- WR_CYCLES, 2, cycles the select line is held during a write (>=1).
- RD_CYCLES, 2, cycles the select line is held before read capture (>=1).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid && ready).
- req0_we / req1_we  in  1  1=write, 0=read.
- req0_addr / req1_addr  in  ADDR_W  row address.
- req0_wdata / req1_wdata  in  WIDTH  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WIDTH  read data; valid only with rspN_valid.
- rsp_err  out  1  address out of range; valid only with rspN_valid.
- busy  out  1  high in every state except IDLE.
- arr_sel  out  ROWS  one-hot row select, or all zero.
- arr_read  out  1  global read line.
- arr_in  out  WIDTH  column write data.
- arr_out  in  WIDTH  OR of all cell outputs.

Behaviour:
- Reset values: arr_sel=0, arr_read=1, arr_in=0, req*_ready=0, rsp*_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE, round-robin pointer=req1 (so req0 wins first).
- Reset applies mid-operation too: all outputs take their reset values on the next edge. An interrupted write leaves only the addressed row undefined; no other row may change.
- States: IDLE, WSETUP, WSEL, WHOLD, RSEL, DONE.
- All outputs are registered. Every arr_* value below holds for the whole listed state.
- IDLE:
  - Outputs: arr_sel=0, arr_read=1.
  - Grant: if only one valid is high, that requester is granted. If both are high, the requester not served last is granted.
  - The granted req*_ready is driven combinationally high for that cycle only.
  - On accept, latch we, addr, wdata and requester id, and set the pointer to this requester.
  - If addr >= ROWS, go to DONE with rsp_err=1 and no array activity. Otherwise go to WSETUP if we=1, else RSEL.
- WSETUP (1 cycle): arr_in=wdata, arr_read=0, arr_sel=0. Data and read settle before any select rises.
- WSEL (WR_CYCLES cycles): arr_sel=onehot(addr), arr_read=0, arr_in held.
- WHOLD (1 cycle): arr_sel=0, arr_read=0, arr_in held, then go to DONE.
- RSEL (RD_CYCLES cycles): arr_sel=onehot(addr), arr_read=1. At the edge ending the last RSEL cycle, register arr_out into rsp_rdata.
- DONE (1 cycle): arr_sel=0, arr_read=1.
  - The served requester's rspN_valid=1; rsp_err is set per the address check.
  - rsp_rdata is 0 for writes and for errors.
  - Then go to IDLE.
- Invariants:
  - arr_read never changes in the same cycle that any arr_sel bit is high.
  - At most one arr_sel bit is high at any time.
- Latency (accept at cycle T):
  - Write: rsp at T+3+WR_CYCLES (T+5 at defaults).
  - Read: rsp at T+1+RD_CYCLES (T+3 at defaults).
  - Error: rsp at T+1.
  - Next accept: earliest one cycle after DONE.
- Requesters hold valid and payload until ready. Payload changes while waiting are allowed and take effect at accept.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with both valid=1 -> arr_sel=0, arr_read=1, no ready, busy=0. Release -> req0_ready=1 on the first IDLE cycle.
- Write then read: req0 writes 0xA5 to row 3, accepted at T -> arr_in=0xA5 and arr_read=0 at T+1; arr_sel=0x0008 at T+2..T+3; sel=0 at T+4; rsp0_valid at T+5. Then req0 reads row 3 -> rsp_rdata=0xA5 at T'+3.
- Isolation: write 0x3C to row 4, then 0xFF to row 3 -> read row 4 returns 0x3C, read row 3 returns 0xFF. Check arr_read is stable whenever arr_sel is nonzero.
- Arbitration: both valid continuously with reads -> grants alternate req0, req1, req0, req1, with rsp0/rsp1 pulses in the same order. Only req1 valid after serving req1 -> req1 granted again.
- Out-of-range: ROWS=12, req1 reads addr 13 -> rsp1_valid with rsp_err=1 and rsp_rdata=0 at T+1; arr_sel stays 0 throughout.
- Reset mid-write: rst_n=0 during WSEL -> next edge arr_sel=0, arr_read=1, no rsp. Rows written earlier read back unchanged.
